// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder: op encoding, chunk sizing and
// the bit offsets used to pack the per-level skew/de-skew registers.
package pipe_adder_pkg;

  // Operation select encoding for the sub input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // True when WIDTH can be split into STAGES equal carry-chain chunks.
  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

  // Bits handled by each stage.
  function automatic int chunk_of(input int width, input int stages);
    return (stages >= 1) ? (width / stages) : width;
  endfunction

  // Skew level k (1..STAGES-1) carries the operand bits not yet consumed,
  // WIDTH - k*CHUNK bits wide. Levels are packed back to back starting at
  // level 1; this returns the LSB position of level k.
  function automatic int skew_off(input int level, input int width, input int chunk);
    return (level - 1) * width - (chunk * level * (level - 1)) / 2;
  endfunction

  // De-skew level k (1..STAGES-1) carries the k result chunks already
  // produced, k*CHUNK bits wide, packed back to back from level 1.
  function automatic int deskew_off(input int level, input int chunk);
    return (chunk * level * (level - 1)) / 2;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the chunk adders are ripple chains of these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/pipe_adder_stage.sv
// One pipeline stage: a CHUNK-bit ripple adder feeding registered partial
// sum, chunk carry-out and valid bit. All registers advance only when en=1.
// The last stage also registers the carry into its MSB so the top level can
// form signed overflow without a combinational path from the operands.
module pipe_adder_stage #(
  parameter int CHUNK   = 8,
  parameter bit IS_LAST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid_in,
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  input  logic             carry_in,
  output logic             valid,
  output logic [CHUNK-1:0] sum_chunk,
  output logic             carry_out,
  output logic             msb_carry
);

  logic [CHUNK:0]   carry;
  logic [CHUNK-1:0] part;

  assign carry[0] = carry_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a    (a_chunk[i]),
      .b    (b_chunk[i]),
      .cin  (carry[i]),
      .sum  (part[i]),
      .cout (carry[i+1])
    );
  end

  // Stage registers: cleared by reset, frozen while the pipe is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= 1'b0;
      sum_chunk <= '0;
      carry_out <= 1'b0;
    end else if (en) begin
      valid     <= valid_in;
      sum_chunk <= part;
      carry_out <= carry[CHUNK];
    end
  end

  if (IS_LAST) begin : g_msb
    logic msb_q;

    // Carry into the result MSB, kept alongside the final chunk for ovf.
    always_ff @(posedge clk) begin
      if (rst) begin
        msb_q <= 1'b0;
      end else if (en) begin
        msb_q <= carry[CHUNK-1];
      end
    end

    assign msb_carry = msb_q;
  end else begin : g_no_msb
    assign msb_carry = 1'b0;
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract with carry-in. The carry chain is cut into STAGES
// registered chunks; operands not yet consumed ride along in skew registers
// and finished low chunks ride along in de-skew registers so the full sum
// appears coherently at the last stage.
//
// Handshake: a beat moves in on an edge with in_valid && in_ready and out on
// an edge with out_valid && out_ready. The whole pipe is one global enable:
// when the output is valid but not accepted, every register holds and
// in_ready drops in the same cycle; otherwise everything advances, so the
// block accepts and emits one beat per cycle. Bubbles are not compressed.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK       = chunk_of(WIDTH, STAGES);
  localparam int SKEW_BITS   = (STAGES > 1) ? skew_off(STAGES, WIDTH, CHUNK) : 1;
  localparam int DESKEW_BITS = (STAGES > 1) ? deskew_off(STAGES, CHUNK) : 1;

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("pipe_adder: WIDTH (%0d) must be a positive multiple of STAGES (%0d)",
           WIDTH, STAGES);
  end

  logic                   stall;
  logic                   en;
  logic [WIDTH-1:0]       b_eff;
  logic                   carry0;
  logic [STAGES-1:0]      v_q;
  logic [STAGES-1:0]      c_q;
  logic [CHUNK-1:0]       s_q [STAGES];
  logic                   last_msb;
  logic [SKEW_BITS-1:0]   skew_a_w;
  logic [SKEW_BITS-1:0]   skew_b_w;
  logic [DESKEW_BITS-1:0] deskew_w;

  // Subtraction is a + ~b + 1; cin only matters for addition.
  assign b_eff  = (sub == OP_SUB) ? ~b : b;
  assign carry0 = (sub == OP_SUB) ? 1'b1 : cin;

  assign out_valid = v_q[STAGES-1];
  assign stall     = out_valid && !out_ready;
  assign en        = !stall;
  assign in_ready  = !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] op_a;
    logic [CHUNK-1:0] op_b;
    logic             op_c;
    logic             op_v;
    logic             msb;

    if (k == 0) begin : g_first
      assign op_a = a[CHUNK-1:0];
      assign op_b = b_eff[CHUNK-1:0];
      assign op_c = carry0;
      assign op_v = in_valid;
    end else begin : g_inner
      localparam int OFF = skew_off(k, WIDTH, CHUNK);
      assign op_a = skew_a_w[OFF +: CHUNK];
      assign op_b = skew_b_w[OFF +: CHUNK];
      assign op_c = c_q[k-1];
      assign op_v = v_q[k-1];
    end

    pipe_adder_stage #(
      .CHUNK   (CHUNK),
      .IS_LAST (k == STAGES - 1)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .valid_in  (op_v),
      .a_chunk   (op_a),
      .b_chunk   (op_b),
      .carry_in  (op_c),
      .valid     (v_q[k]),
      .sum_chunk (s_q[k]),
      .carry_out (c_q[k]),
      .msb_carry (msb)
    );

    if (k == STAGES - 1) begin : g_last
      assign last_msb = msb;
    end else begin : g_tie
      logic unused_msb;
      assign unused_msb = msb;
    end
  end

  // Level k sits beside stage k-1's registers and belongs to the same beat.
  for (genvar k = 1; k < STAGES; k++) begin : g_level
    localparam int SW   = WIDTH - k * CHUNK;
    localparam int SOFF = skew_off(k, WIDTH, CHUNK);
    localparam int DW   = k * CHUNK;
    localparam int DOFF = deskew_off(k, CHUNK);

    logic [SW-1:0] sa_d;
    logic [SW-1:0] sb_d;
    logic [DW-1:0] ds_d;
    logic [SW-1:0] sa_q;
    logic [SW-1:0] sb_q;
    logic [DW-1:0] ds_q;

    if (k == 1) begin : g_from_in
      assign sa_d = a[WIDTH-1:CHUNK];
      assign sb_d = b_eff[WIDTH-1:CHUNK];
      assign ds_d = s_q[0];
    end else begin : g_from_prev
      localparam int PSOFF = skew_off(k - 1, WIDTH, CHUNK);
      localparam int PDOFF = deskew_off(k - 1, CHUNK);
      // Drop the chunk the previous stage just consumed.
      assign sa_d = skew_a_w[PSOFF + CHUNK +: SW];
      assign sb_d = skew_b_w[PSOFF + CHUNK +: SW];
      // Newest finished chunk goes on top of the older low chunks.
      assign ds_d = {s_q[k-1], deskew_w[PDOFF +: DW - CHUNK]};
    end

    // Unconsumed operand bits travel with the beat; contents of empty slots
    // are never observed, so these need no reset.
    always_ff @(posedge clk) begin
      if (en) begin
        sa_q <= sa_d;
        sb_q <= sb_d;
      end
    end

    // Finished low chunks travel with the beat; cleared so sum reads 0 after reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        ds_q <= '0;
      end else if (en) begin
        ds_q <= ds_d;
      end
    end

    assign skew_a_w[SOFF +: SW] = sa_q;
    assign skew_b_w[SOFF +: SW] = sb_q;
    assign deskew_w[DOFF +: DW] = ds_q;
  end

  if (STAGES > 1) begin : g_sum_multi
    assign sum = {s_q[STAGES-1], deskew_w[deskew_off(STAGES - 1, CHUNK) +: (STAGES - 1) * CHUNK]};
  end else begin : g_sum_single
    assign sum = s_q[0];
  end

  assign cout = c_q[STAGES-1];
  assign ovf  = last_msb ^ c_q[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: a stimulus thread issues beats, a negedge monitor
// pushes the reference result for every accepted beat into exp_q and pops
// and compares whenever the DUT hands a result downstream.
module tb_pipe_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int               checks = 0;
  int               errors = 0;
  int unsigned      cyc = 0;
  int unsigned      issue_cyc = 0;
  int               out_count = 0;
  logic [WIDTH+1:0] exp_q[$];
  logic             held_valid = 1'b0;
  logic [WIDTH+1:0] held_val = '0;
  logic             stress_done;

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Returns {cout, ovf, sum} from plain wide arithmetic.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                             input logic mcin, input logic msub);
    longint unsigned ua, ub, ur;
    longint          sa, sb, sr, smax, smin;
    logic            co, ov;
    ua   = ma;
    ub   = mb;
    sa   = longint'($signed(ma));
    sb   = longint'($signed(mb));
    smax = (longint'(1) <<< (WIDTH - 1)) - 1;
    smin = -(longint'(1) <<< (WIDTH - 1));
    if (msub) begin
      ur = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end else begin
      ur = ua + ub + longint'(mcin);
      sr = sa + sb + longint'(mcin);
      co = ((ur >> WIDTH) != 0);
    end
    ov = (sr > smax) || (sr < smin);
    return {co, ov, ur[WIDTH-1:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held_valid = 1'b0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (held_valid && out_valid) begin
        check("hold", 64'({cout, ovf, sum}), 64'(held_val));
      end
      if (out_valid && out_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h, required no output", {cout, ovf, sum});
        end else begin
          logic [WIDTH+1:0] e;
          e = exp_q.pop_front();
          check("sum", 64'(sum), 64'(e[WIDTH-1:0]));
          check("cout", 64'(cout), 64'(e[WIDTH+1]));
          check("ovf", 64'(ovf), 64'(e[WIDTH]));
        end
      end
      held_valid = out_valid && !out_ready;
      held_val   = {cout, ovf, sum};
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        issue_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                           input logic tcin, input logic tsub);
    int guard;
    guard    = 0;
    a        = ta;
    b        = tb;
    cin      = tcin;
    sub      = tsub;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 100 cycles, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Single beat with an idle pipe; also checks the input-to-output latency.
  task automatic directed(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tcin, input logic tsub);
    int guard;
    send_beat(ta, tb, tcin, tsub);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!out_valid && guard < 20);
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL latency_timeout: got no out_valid in 20 cycles, required %0d", STAGES);
    end else begin
      check("latency", 64'(cyc - issue_cyc), 64'(STAGES));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      guard++;
      @(posedge clk);
      #1;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(WIDTH-1){1'b1}}};
      3:       return {1'b1, {(WIDTH-1){1'b0}}};
      default: return WIDTH'($urandom());
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int unsigned t0;
    int          base;
    int          cnt;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    stress_done = 1'b0;

    // Reset defaults
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Directed corner cases
    directed(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    directed(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    directed(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    directed(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    directed(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
    wait_drain();

    // Backpressure stream: 10 back-to-back beats, out_ready low in cycles 3..8
    base = out_count;
    t0   = cyc;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send_beat(WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end
        check("stream_cycles", 64'(cyc - t0), 64'(15));
      end
      begin
        for (int c = 0; c < 12; c++) begin
          out_ready = !(c >= 3 && c <= 8);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stream_count", 64'(out_count - base), 64'(10));

    // Random traffic with random backpressure
    base = out_count;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_beat(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end
        stress_done = 1'b1;
      end
      begin
        while (!stress_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("random_count", 64'(out_count - base), 64'(60));

    // Reset mid-flight: three beats discarded, next beat normal
    out_ready = 1'b1;
    base      = out_count;
    for (int i = 0; i < 3; i++) begin
      send_beat(WIDTH'($urandom()), WIDTH'($urandom()), 1'b0, 1'b0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("flush_no_output", 64'(cnt), 64'(0));
    check("flush_count", 64'(out_count - base), 64'(0));
    @(posedge clk);
    #1;
    directed(32'hDEAD_BEEF, 32'h2152_4111, 1'b1, 1'b0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, required finish");
    $fatal(1, "timeout");
  end

endmodule
